// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants and state encoding for the channel-mux scan sequencer.
// The mux is fixed at eight 3-bit channels, so the select bus is 3 bits wide
// and a packed frame holds NUM_CH*DW bits.
package mux_scan_sequencer_pkg;

   localparam int NUM_CH         = 8;
   localparam int DW             = 3;
   localparam int SEL_W          = 3;
   localparam int FRAME_W        = NUM_CH * DW;
   localparam int SETTLE_DEFAULT = 1;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2
   } scanState_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bundles the scan request, mux select/readback and frame handshake signals.
// The master side is the sequencer; the slave side is the surrounding system
// (requester, channel mux and frame consumer).
interface mux_scan_sequencer_if
   import mux_scan_sequencer_pkg::*;
   ();

   logic                 start;
   logic [NUM_CH-1:0]    ch_mask;
   logic [DW-1:0]        mux_out;
   logic [SEL_W-1:0]     sel;
   logic                 busy;
   logic                 frame_valid;
   logic                 frame_ready;
   logic [FRAME_W-1:0]   frame_data;
   logic [NUM_CH-1:0]    frame_mask;
   logic                 overrun;

   modport master (
      input  start, ch_mask, mux_out, frame_ready,
      output sel, busy, frame_valid, frame_data, frame_mask, overrun
   );

   modport slave (
      output start, ch_mask, mux_out, frame_ready,
      input  sel, busy, frame_valid, frame_data, frame_mask, overrun
   );

endinterface

// File: rtl/mux_scan_sequencer_next_ch_finder.sv
// Finds the next enabled channel in a mask. With first set it returns the
// lowest enabled channel; otherwise the lowest enabled channel strictly above
// cur. none flags that no such channel exists.
module NextChFinder
   import mux_scan_sequencer_pkg::*;
   (
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              first,
   output logic [SEL_W-1:0]  nextIdx,
   output logic              none
   );

   // Walk from the top channel downwards so the last hit is the lowest
   // qualifying channel, which is the one the scan visits next.
   always_comb begin
      nextIdx = '0;
      none    = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (first || (i > int'(cur)))) begin
            nextIdx = SEL_W'(i);
            none    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the 8-to-1 channel mux: on start it walks every enabled
// channel, waits SETTLE cycles after each select change, captures the mux
// output, and hands the packed frame downstream over a valid/ready handshake.
module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
   #(
   parameter int SETTLE = SETTLE_DEFAULT
   )
   (
   input  logic                 clk,
   input  logic                 rst,
   mux_scan_sequencer_if.master bus
   );

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

   scanState_t          state;
   logic [NUM_CH-1:0]   maskLat;
   logic [FRAME_W-1:0]  capture;
   logic [FRAME_W-1:0]  captureNext;
   logic [CNT_W-1:0]    settleCnt;
   logic [SEL_W-1:0]    selReg;
   logic                busyReg;
   logic                frameValidReg;
   logic [FRAME_W-1:0]  frameDataReg;
   logic [NUM_CH-1:0]   frameMaskReg;
   logic                overrunReg;
   logic                firstSearch;
   logic [NUM_CH-1:0]   searchMask;
   logic [SEL_W-1:0]    nextCh;
   logic                noneLeft;

   assign firstSearch = (state == S_IDLE);
   assign searchMask  = firstSearch ? bus.ch_mask : maskLat;

   NextChFinder finder (
      .mask    (searchMask),
      .cur     (selReg),
      .first   (firstSearch),
      .nextIdx (nextCh),
      .none    (noneLeft)
   );

   // Capture register with the current mux reading merged into the field of
   // the selected channel; used both for the running capture and the frame.
   always_comb begin
      captureNext = capture;
      captureNext[int'(selReg) * DW +: DW] = bus.mux_out;
   end

   // Scan FSM plus every registered output. Frame consumption is applied first
   // so that a frame completing on the same edge overrides the clear and the
   // old frame simply counts as taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         maskLat       <= '0;
         capture       <= '0;
         settleCnt     <= '0;
         selReg        <= '0;
         busyReg       <= 1'b0;
         frameValidReg <= 1'b0;
         frameDataReg  <= '0;
         frameMaskReg  <= '0;
         overrunReg    <= 1'b0;
      end else begin
         if (frameValidReg && bus.frame_ready) begin
            frameValidReg <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (bus.start && (bus.ch_mask != '0)) begin
                  maskLat   <= bus.ch_mask;
                  capture   <= '0;
                  selReg    <= nextCh;
                  settleCnt <= SETTLE_LD;
                  busyReg   <= 1'b1;
                  if (SETTLE == 0) begin
                     state <= S_SAMPLE;
                  end else begin
                     state <= S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               settleCnt <= settleCnt - 1'b1;
               if (settleCnt <= CNT_W'(1)) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               capture <= captureNext;
               if (!noneLeft) begin
                  selReg    <= nextCh;
                  settleCnt <= SETTLE_LD;
                  if (SETTLE == 0) begin
                     state <= S_SAMPLE;
                  end else begin
                     state <= S_SETTLE;
                  end
               end else begin
                  frameDataReg  <= captureNext;
                  frameMaskReg  <= maskLat;
                  frameValidReg <= 1'b1;
                  if (frameValidReg && !bus.frame_ready) begin
                     overrunReg <= 1'b1;
                  end
                  busyReg <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sel         = selReg;
   assign bus.busy        = busyReg;
   assign bus.frame_valid = frameValidReg;
   assign bus.frame_data  = frameDataReg;
   assign bus.frame_mask  = frameMaskReg;
   assign bus.overrun     = overrunReg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer. A behavioural mux returns a per-channel value
// for the selected channel; expected frames, latencies and select sequences
// are derived from the enabled-channel list and the settle time.
module tb_mux_scan_sequencer;
   import mux_scan_sequencer_pkg::*;

   localparam int SETTLE = 1;
   localparam int CYC    = SETTLE + 1;

   logic clk = 1'b0;
   logic rst;
   logic [DW-1:0] chanVal [NUM_CH];
   logic overrideOn;
   int   vectors     = 0;
   int   miscompares = 0;
   bit   modelPending;
   bit   modelOverrun;

   mux_scan_sequencer_if bus ();

   mux_scan_sequencer #(.SETTLE(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Behavioural channel mux; overrideOn forces a foreign value onto the bus.
   assign bus.mux_out = overrideOn ? 3'd5 : chanVal[bus.sel];

   // Compare one observed value against the bench's own expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Frame a scan should produce: enabled channels carry their mux value,
   // disabled channels read zero.
   function automatic logic [FRAME_W-1:0] modelFrame(input logic [NUM_CH-1:0] mask);
      logic [FRAME_W-1:0] f = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i]) f[i*DW +: DW] = chanVal[i];
      end
      return f;
   endfunction

   // Issue one start and follow the scan until busy drops. n counts edges
   // after the accept edge; during the cycle after edge n the select must be
   // the (n / CYC)-th enabled channel.
   task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input bit glitch,
                                input bit repulse, input bit readyAtEnd,
                                output int latency, output int selErrs);
      int enabled[$];
      int expLat;
      int n;
      int idx;
      for (int i = 0; i < NUM_CH; i++) if (mask[i]) enabled.push_back(i);
      expLat = enabled.size() * CYC;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.ch_mask = mask;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.ch_mask = NUM_CH'($urandom);
      n       = 0;
      selErrs = 0;
      while (bus.busy === 1'b1 && n < 400) begin
         idx = n / CYC;
         if (idx > enabled.size() - 1) idx = enabled.size() - 1;
         if (enabled.size() > 0 && int'(bus.sel) != enabled[idx]) selErrs++;
         overrideOn = glitch && ((n % CYC) < SETTLE);
         bus.start  = repulse && (n == 2);
         if (bus.start) bus.ch_mask = 8'h01;
         if (readyAtEnd) bus.frame_ready = (n == expLat - 1);
         @(negedge clk);
         n++;
      end
      overrideOn = 1'b0;
      bus.start  = 1'b0;
      latency    = n;
   endtask

   // Full scan with every result checked against the model.
   task automatic runScan(input string tag, input logic [NUM_CH-1:0] mask,
                          input bit glitch, input bit repulse, input bit readyAtEnd);
      logic [FRAME_W-1:0] expFrame;
      int lat;
      int selErrs;
      bit readyAtDone;
      expFrame    = modelFrame(mask);
      readyAtDone = readyAtEnd || bus.frame_ready;
      applyStimulus(mask, glitch, repulse, readyAtEnd, lat, selErrs);
      if (readyAtEnd) bus.frame_ready = 1'b0;
      if (modelPending && !readyAtDone) modelOverrun = 1'b1;
      modelPending = 1'b1;
      checkOutput({tag, ".latency"}, lat, $countones(mask) * CYC);
      checkOutput({tag, ".selSeq"}, selErrs, 0);
      checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
      checkOutput({tag, ".valid"}, 32'(bus.frame_valid), 1);
      checkOutput({tag, ".data"}, 32'(bus.frame_data), 32'(expFrame));
      checkOutput({tag, ".mask"}, 32'(bus.frame_mask), 32'(mask));
      checkOutput({tag, ".overrun"}, 32'(bus.overrun), 32'(modelOverrun));
      if (bus.frame_ready) begin
         @(negedge clk);
         modelPending = 1'b0;
         checkOutput({tag, ".consumed"}, 32'(bus.frame_valid), 0);
      end
   endtask

   // Directed steps followed by a randomized batch.
   initial begin
      int errs;
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.ch_mask     = '0;
      bus.frame_ready = 1'b1;
      overrideOn      = 1'b0;
      modelPending    = 1'b0;
      modelOverrun    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) chanVal[i] = DW'(i);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset values");
      checkOutput("rst.sel", 32'(bus.sel), 0);
      checkOutput("rst.busy", 32'(bus.busy), 0);
      checkOutput("rst.valid", 32'(bus.frame_valid), 0);
      checkOutput("rst.data", 32'(bus.frame_data), 0);
      checkOutput("rst.mask", 32'(bus.frame_mask), 0);
      checkOutput("rst.overrun", 32'(bus.overrun), 0);

      $display("[TB] start with empty mask");
      bus.start   = 1'b1;
      bus.ch_mask = '0;
      @(negedge clk);
      bus.start = 1'b0;
      errs = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.busy !== 1'b0 || bus.sel !== '0 || bus.frame_valid !== 1'b0) errs++;
         @(negedge clk);
      end
      checkOutput("mask0.idle", errs, 0);

      $display("[TB] full and sparse scans");
      runScan("full", 8'hFF, 1'b0, 1'b0, 1'b0);
      runScan("sparse", 8'hA5, 1'b0, 1'b0, 1'b0);
      runScan("glitch", 8'hFF, 1'b1, 1'b1, 1'b0);

      $display("[TB] overrun");
      bus.frame_ready = 1'b0;
      runScan("ovr1", 8'h01, 1'b0, 1'b0, 1'b0);
      runScan("ovr2", 8'h02, 1'b0, 1'b0, 1'b0);
      bus.frame_ready = 1'b1;
      @(negedge clk);
      modelPending = 1'b0;
      checkOutput("ovr.consumed", 32'(bus.frame_valid), 0);
      checkOutput("ovr.sticky", 32'(bus.overrun), 1);

      $display("[TB] completion coinciding with consume");
      rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      modelOverrun = 1'b0;
      bus.frame_ready = 1'b0;
      runScan("same1", 8'h10, 1'b0, 1'b0, 1'b0);
      runScan("same2", 8'h81, 1'b0, 1'b0, 1'b1);
      bus.frame_ready = 1'b1;
      @(negedge clk);
      modelPending = 1'b0;
      checkOutput("same.consumed", 32'(bus.frame_valid), 0);

      $display("[TB] reset mid-scan");
      @(negedge clk);
      bus.start   = 1'b1;
      bus.ch_mask = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      modelOverrun = 1'b0;
      modelPending = 1'b0;
      checkOutput("midRst.sel", 32'(bus.sel), 0);
      checkOutput("midRst.busy", 32'(bus.busy), 0);
      checkOutput("midRst.valid", 32'(bus.frame_valid), 0);
      checkOutput("midRst.data", 32'(bus.frame_data), 0);
      runScan("afterRst", 8'hFF, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized scans");
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < NUM_CH; i++) chanVal[i] = DW'($urandom_range(0, 7));
         runScan("rand", NUM_CH'($urandom_range(1, 255)), 1'($urandom),
                 1'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
